jtdsp16_sout: RTL and testbench

- Receives the DSP16 serial output port (ock, sdo, old, sadd) and rebuilds complete parallel 16-bit stereo sample pairs.
- Sits directly downstream of the jtdsp16 top level. It is the sample sink that the QSound sound board's mixer/DAC consumes.
- Drives doen back to the DSP, so the DSP only shifts data when this receiver is enabled.
- Runs on the same clk as the DSP and treats ock as a synchronous level sampled at clk.

---
 rtl/jtdsp16_pkg.sv | 14 +
 rtl/jtdsp16_sout_shift.sv | 98 +++++++++
 rtl/jtdsp16_sout.sv | 97 +++++++++
 tb/tb_jtdsp16_sout.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 serial output receiver: FSM states and channel tags.
package jtdsp16_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    localparam int OUT_W = 16;

endpackage

// File: rtl/jtdsp16_sout_shift.sv
// Serial word deserializer: ock rise detect, shift register, bit counter and a
// registered word-done strobe issued one clk after the final bit is captured.
module jtdsp16_sout_shift
    import jtdsp16_pkg::*;
#(
    parameter int WORD_LEN  = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ock,
    input  logic             sdo,
    input  logic             old,
    output logic             word_start,
    output logic             restart,
    output logic             word_done,
    output logic [OUT_W-1:0] word
);

    localparam int CNT_W = $clog2(WORD_LEN) + 1;

    logic                ock_l;
    logic                rise;
    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_LEN-1:0] sreg;
    logic [WORD_LEN-1:0] sreg_base;
    logic [WORD_LEN-1:0] sreg_nx;
    logic                capture;
    logic                last_bit;
    logic                complete;

    assign rise = ock & ~ock_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ock_l <= 1'b0;
        else        ock_l <= ock;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = ST_IDLE;
        end else if (rise) begin
            case (state)
                ST_IDLE:  if (old) state_nx = ST_SHIFT;
                ST_SHIFT: begin
                    if (old)           state_nx = ST_SHIFT;
                    else if (last_bit) state_nx = ST_IDLE;
                end
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // A word start always wins over an in-progress word; starting in SHIFT is a framing error.
    always_comb begin
        word_start = en & rise & old;
        restart    = word_start & (state == ST_SHIFT);
        capture    = en & rise & (old | (state == ST_SHIFT));
        last_bit   = (state == ST_SHIFT) & ~old & (cnt == CNT_W'(WORD_LEN - 1));
        complete   = en & rise & last_bit;
    end

    always_comb begin
        sreg_base = old ? '0 : sreg;
        if (MSB_FIRST) sreg_nx = {sreg_base[WORD_LEN-2:0], sdo};
        else           sreg_nx = {sdo, sreg_base[WORD_LEN-1:1]};
    end

    always_ff @(posedge clk) begin
        if (capture) sreg <= sreg_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= complete;
            if (capture) cnt <= old ? CNT_W'(1) : cnt + CNT_W'(1);
        end
    end

    // Narrow words are zero-extended to the 16-bit sample width.
    always_comb begin
        word                 = '0;
        word[WORD_LEN-1:0]   = sreg;
    end

endmodule

// File: rtl/jtdsp16_sout.sv
// DSP16 serial output sink: pairs left/right words into stereo samples and
// tracks framing errors (early load, missing left, repeated left).
module jtdsp16_sout
    import jtdsp16_pkg::*;
#(
    parameter int WORD_LEN  = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ock,
    input  logic             sdo,
    input  logic             old,
    input  logic             sadd,
    output logic             doen,
    input  logic             clr_err,
    output logic [OUT_W-1:0] left,
    output logic [OUT_W-1:0] right,
    output logic             sample,
    output logic             frame_err
);

    logic             word_start;
    logic             restart;
    logic             word_done;
    logic [OUT_W-1:0] word;
    logic             ch;
    logic             left_pend;
    logic [OUT_W-1:0] hold;
    logic             pair_err;
    logic             err_evt;

    jtdsp16_sout_shift #(
        .WORD_LEN  (WORD_LEN),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ock        (ock),
        .sdo        (sdo),
        .old        (old),
        .word_start (word_start),
        .restart    (restart),
        .word_done  (word_done),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) doen <= 1'b0;
        else        doen <= en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ch <= CH_RIGHT;
        else if (word_start) ch <= sadd;
    end

    // A finished left word must find the slot empty; a finished right word must find it full.
    always_comb begin
        pair_err = word_done & en & ((ch == CH_LEFT) ? left_pend : ~left_pend);
        err_evt  = restart | pair_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left      <= '0;
            right     <= '0;
            hold      <= '0;
            sample    <= 1'b0;
            left_pend <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (!en) begin
                left_pend <= 1'b0;
            end else if (word_done) begin
                if (ch == CH_LEFT) begin
                    hold      <= word;
                    left_pend <= 1'b1;
                end else begin
                    if (left_pend) left <= hold;
                    right     <= word;
                    sample    <= 1'b1;
                    left_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       frame_err <= 1'b0;
        else if (err_evt) frame_err <= 1'b1;
        else if (clr_err) frame_err <= 1'b0;
    end

endmodule

// File: tb/tb_jtdsp16_sout.sv
// Scoreboard bench for jtdsp16_sout: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_jtdsp16_sout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ock = 1'b0;
    logic        sdo = 1'b0;
    logic        old = 1'b0;
    logic        sadd = 1'b0;
    logic        clr_err = 1'b0;
    logic        doen_m, doen_l;
    logic [15:0] left_m, right_m, left_l, right_l;
    logic        sample_m, sample_l, ferr_m, ferr_l;

    jtdsp16_sout #(.WORD_LEN(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .en(en), .ock(ock), .sdo(sdo), .old(old), .sadd(sadd),
        .doen(doen_m), .clr_err(clr_err), .left(left_m), .right(right_m),
        .sample(sample_m), .frame_err(ferr_m)
    );

    jtdsp16_sout #(.WORD_LEN(16), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .ock(ock), .sdo(sdo), .old(old), .sadd(sadd),
        .doen(doen_l), .clr_err(clr_err), .left(left_l), .right(right_l),
        .sample(sample_l), .frame_err(ferr_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          c;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];
    exp_t xm, xl;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: raw (as-transmitted) word values
    logic [15:0] m_left = '0;
    logic [15:0] m_pv   = '0;
    logic        m_pend = 1'b0;
    logic        m_partial = 1'b0;
    logic        m_err  = 1'b0;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sample_m) begin
            if (q_m.size() == 0) begin
                chk("msb_unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                xm = q_m.pop_front();
                chk("msb_left",  32'(left_m),  32'(xm.l));
                chk("msb_right", 32'(right_m), 32'(xm.r));
                chk("msb_cycle", 32'(cyc),     32'(xm.c));
            end
        end
        if (sample_l) begin
            if (q_l.size() == 0) begin
                chk("lsb_unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                xl = q_l.pop_front();
                chk("lsb_left",  32'(left_l),  32'(xl.l));
                chk("lsb_right", 32'(right_l), 32'(xl.r));
                chk("lsb_cycle", 32'(cyc),     32'(xl.c));
            end
        end
    end

    task automatic model_reset();
        m_left = '0; m_pv = '0; m_pend = 1'b0; m_partial = 1'b0; m_err = 1'b0;
        q_m.delete(); q_l.delete();
    endtask

    // Sends the first nbits of v (transmitted MSB first); starts and ends at a negedge.
    task automatic send_word(input logic [15:0] v, input logic tag, input int nbits, input logic clr_first);
        int e = 0;
        logic [15:0] l;
        for (int i = 0; i < nbits; i++) begin
            ock = 1'b0; sdo = v[15-i]; old = (i == 0); sadd = (i == 0) ? tag : 1'($urandom);
            @(negedge clk);
            ock = 1'b1;
            if (i == 0 && clr_first) clr_err = 1'b1;
            @(posedge clk); #1; e = cyc;
            @(negedge clk);
            clr_err = 1'b0;
        end
        old = 1'b0;
        if (nbits > 0) begin
            if (m_partial)      m_err = 1'b1;
            else if (clr_first) m_err = 1'b0;
            m_partial = (nbits < 16);
        end
        if (nbits == 16) begin
            if (tag) begin
                if (m_pend) m_err = 1'b1;
                m_pend = 1'b1; m_pv = v;
            end else begin
                if (!m_pend) m_err = 1'b1;
                l = m_pend ? m_pv : m_left;
                q_m.push_back('{l, v, e + 1});
                q_l.push_back('{rev16(l), rev16(v), e + 1});
                m_left = l; m_pend = 1'b0;
            end
        end
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) begin
            ock = 1'b0; sdo = 1'($urandom); old = 1'b0; sadd = 1'($urandom);
            @(negedge clk); ock = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic clr_pulse();
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic en_drop();
        en = 1'b0;
        m_pend = 1'b0; m_partial = 1'b0;
        repeat (2) @(negedge clk);
        chk("doen_low", 32'(doen_m), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("doen_high", 32'(doen_m), 32'd1);
    endtask

    task automatic check_state(input string nm);
        repeat (2) @(negedge clk);
        chk({nm, "_err_msb"}, 32'(ferr_m), 32'(m_err));
        chk({nm, "_err_lsb"}, 32'(ferr_l), 32'(m_err));
    endtask

    initial begin
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_left",  32'(left_m),   32'd0);
        chk("rst_right", 32'(right_m),  32'd0);
        chk("rst_doen",  32'(doen_m),   32'd0);
        rst_n = 1'b1;
        #1 chk("doen_before_edge", 32'(doen_m), 32'd0);
        @(negedge clk);
        chk("doen_after_edge", 32'(doen_m), 32'd1);

        // Normal pair, also seen bit-reversed by the LSB-first instance
        send_word(16'h1234, 1'b1, 16, 1'b0);
        send_word(16'hABCD, 1'b0, 16, 1'b0);
        check_state("pair");
        chk("pair_left_m",  32'(left_m),  32'h1234);
        chk("pair_right_m", 32'(right_m), 32'hABCD);
        chk("pair_left_l",  32'(left_l),  32'h2C48);
        chk("pair_right_l", 32'(right_l), 32'hB3D5);

        // Missing left: two right words
        send_word(16'h0001, 1'b0, 16, 1'b0);
        send_word(16'h0002, 1'b0, 16, 1'b0);
        check_state("missing_left");
        chk("missing_left_keep", 32'(left_m), 32'h1234);
        clr_pulse();
        check_state("clr");

        // Early load: partial word then full word
        send_word(16'hFFFF, 1'b1, 5, 1'b0);
        send_word(16'h5555, 1'b1, 16, 1'b0);
        send_word(16'h0F0F, 1'b0, 16, 1'b0);
        check_state("early_old");
        chk("early_old_left", 32'(left_m), 32'h5555);
        clr_pulse();

        // Error and clear on the same edge: error must win
        send_word(16'h1357, 1'b1, 3, 1'b0);
        send_word(16'h2468, 1'b1, 16, 1'b1);
        send_word(16'h9999, 1'b0, 16, 1'b0);
        check_state("err_vs_clr");
        clr_pulse();

        // Enable drop mid-word, then a fresh pair
        send_word(16'hAAAA, 1'b1, 8, 1'b0);
        en_drop();
        send_word(16'h00FF, 1'b1, 16, 1'b0);
        send_word(16'hFF00, 1'b0, 16, 1'b0);
        check_state("en_drop");
        chk("en_drop_left",  32'(left_m),  32'h00FF);
        chk("en_drop_right", 32'(right_m), 32'hFF00);

        // Completed left discarded by enable drop
        send_word(16'h7777, 1'b1, 16, 1'b0);
        en_drop();
        send_word(16'h1111, 1'b0, 16, 1'b0);
        check_state("pend_drop");
        chk("pend_drop_left", 32'(left_m), 32'h00FF);
        clr_pulse();

        // Two lefts in a row
        send_word(16'h1111, 1'b1, 16, 1'b0);
        send_word(16'h2222, 1'b1, 16, 1'b0);
        send_word(16'h3333, 1'b0, 16, 1'b0);
        check_state("double_left");
        clr_pulse();

        // Reset in the middle of a word
        send_word(16'hC3C3, 1'b1, 7, 1'b0);
        send_word(16'h0000, 1'b0, 16, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_left",  32'(left_m),  32'd0);
        chk("midrst_right", 32'(right_m), 32'd0);
        chk("midrst_err",   32'(ferr_m),  32'd0);
        chk("midrst_doen",  32'(doen_m),  32'd0);
        chk("midrst_smp",   32'(sample_m), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_doen_hold", 32'(doen_m), 32'd0);
        @(negedge clk);
        chk("midrst_doen_rise", 32'(doen_m), 32'd1);

        // Randomized mix of normal traffic and framing faults
        for (int it = 0; it < 30; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                5: begin
                    send_word(16'($urandom), 1'($urandom), int'($urandom_range(1, 15)), 1'b0);
                    send_word(16'($urandom), 1'b1, 16, 1'($urandom));
                    send_word(16'($urandom), 1'b0, 16, 1'b0);
                end
                6: send_word(16'($urandom), 1'b0, 16, 1'b0);
                7: begin
                    send_word(16'($urandom), 1'b1, 16, 1'b0);
                    send_word(16'($urandom), 1'b1, 16, 1'b0);
                    send_word(16'($urandom), 1'b0, 16, 1'b0);
                end
                8: begin
                    send_word(16'($urandom), 1'b1, int'($urandom_range(1, 15)), 1'b0);
                    en_drop();
                    send_word(16'($urandom), 1'b1, 16, 1'b0);
                    send_word(16'($urandom), 1'b0, 16, 1'b0);
                end
                9: begin
                    clr_pulse();
                    junk(int'($urandom_range(1, 4)));
                    send_word(16'($urandom), 1'b1, 16, 1'b0);
                    send_word(16'($urandom), 1'b0, 16, 1'b0);
                end
                default: begin
                    send_word(16'($urandom), 1'b1, 16, 1'b0);
                    send_word(16'($urandom), 1'b0, 16, 1'b0);
                end
            endcase
            check_state("rand");
        end

        repeat (5) @(negedge clk);
        chk("msb_missing_strobes", 32'(q_m.size()), 32'd0);
        chk("lsb_missing_strobes", 32'(q_l.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
